// File: rtl/cpu_decoder_types_pkg.sv
// Shared decoder types for the block-transfer sequencer and the Thumb decoder.
// Holds the LDM/STM addressing mode, the packed request bundle, the sequencer
// state type and two small helpers (mode decode, register-list popcount).
package cpu_decoder_types_pkg;

  localparam int BX_MAX_REGS  = 16;
  localparam int BX_MAX_IDX_W = 4;

  typedef enum logic [1:0] {
    IA = 2'd0,
    IB = 2'd1,
    DA = 2'd2,
    DB = 2'd3
  } block_xfer_mode_t;

  typedef struct packed {
    logic       p;
    logic       u;
    logic       s;
    logic       w;
    logic       load;
    logic [3:0] rn;
    logic [15:0] reg_list;
  } block_xfer_req_t;

  typedef enum logic [1:0] {
    BX_IDLE = 2'd0,
    BX_XFER = 2'd1,
    BX_FIN  = 2'd2
  } block_xfer_state_t;

  function automatic block_xfer_mode_t bx_mode(input logic p, input logic u);
    block_xfer_mode_t m;
    case ({p, u})
      2'b01:   m = IA;
      2'b11:   m = IB;
      2'b00:   m = DA;
      default: m = DB;
    endcase
    return m;
  endfunction

  function automatic logic [4:0] bx_popcount(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + 5'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/cpu_lowest_set_bit.sv
// Combinational priority encoder: index and one-hot mask of the lowest set bit.
// found_o is low when vec_i is all zeros (idx_o and onehot_o are then 0).
module cpu_lowest_set_bit #(
  parameter int W  = 16,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic [W-1:0]  onehot_o,
  output logic          found_o
);

  // Two's-complement trick isolates the lowest set bit.
  assign onehot_o = vec_i & (~vec_i + W'(1));
  assign found_o  = |vec_i;

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/cpu_block_xfer_seq.sv
// LDM/STM/PUSH/POP micro-sequencer: one bus transfer per listed register,
// ascending register order and ascending addresses, then a done/writeback cycle.
// Build option: CPU_BLOCK_XFER_EMPTY_LIST_EN selects the ARMv4 empty-list quirk
// (single R15 transfer, base moved by 4*NUM_REGS); undefined means an empty
// list does no transfers.
//
// state   | meaning
// --------+--------------------------------------------------------------
// BX_IDLE | waiting for start; all outputs low
// BX_XFER | xfer_valid high, one register per xfer_ready handshake
// BX_FIN  | done pulse, optional base writeback pulse
module cpu_block_xfer_seq
  import cpu_decoder_types_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 32,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                req_p,
  input  logic                req_u,
  input  logic                req_s,
  input  logic                req_w,
  input  logic                req_load,
  input  logic [IDX_W-1:0]    req_rn,
  input  logic [NUM_REGS-1:0] req_reg_list,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                flush,
  output logic                busy,
  output logic                xfer_valid,
  input  logic                xfer_ready,
  output logic [ADDR_W-1:0]   xfer_addr,
  output logic [IDX_W-1:0]    xfer_reg,
  output logic                xfer_load,
  output logic                xfer_user_bank,
  output logic                xfer_last,
  output logic                wb_valid,
  output logic [ADDR_W-1:0]   wb_data,
  output logic                done
);

  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);
`ifdef CPU_BLOCK_XFER_EMPTY_LIST_EN
  localparam logic [NUM_REGS-1:0] TOP_REG_MASK = {1'b1, {(NUM_REGS-1){1'b0}}};
`endif

  block_xfer_state_t   state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   wb_q, wb_d;
  logic [NUM_REGS-1:0] mask_q, mask_d;
  logic                load_q, load_d;
  logic                ub_q, ub_d;
  logic                wb_en_q, wb_en_d;

  block_xfer_req_t     req_in;
  logic [4:0]          n_raw, n_eff;
  logic [NUM_REGS-1:0] mask_init;
  logic [ADDR_W-1:0]   four_n, base_al, start_addr, wb_calc;
  logic                ub_calc, wb_en_calc;

  logic [IDX_W-1:0]    lsb_idx;
  logic [NUM_REGS-1:0] lsb_onehot;
  logic                lsb_found;
  logic                last_xfer;
  logic                in_xfer, in_fin;

  cpu_lowest_set_bit #(
    .W  (NUM_REGS),
    .IW (IDX_W)
  ) u_lsb (
    .vec_i    (mask_q),
    .idx_o    (lsb_idx),
    .onehot_o (lsb_onehot),
    .found_o  (lsb_found)
  );

  assign last_xfer = lsb_found && ((mask_q & ~lsb_onehot) == '0);

  // Bundle the request and precompute start address, writeback and flags.
  always_comb begin
    req_in          = '0;
    req_in.p        = req_p;
    req_in.u        = req_u;
    req_in.s        = req_s;
    req_in.w        = req_w;
    req_in.load     = req_load;
    req_in.rn       = 4'(req_rn);
    req_in.reg_list = 16'(req_reg_list);

    n_raw = bx_popcount(req_in.reg_list);
`ifdef CPU_BLOCK_XFER_EMPTY_LIST_EN
    n_eff     = (n_raw == '0) ? 5'(NUM_REGS) : n_raw;
    mask_init = (n_raw == '0) ? TOP_REG_MASK : req_reg_list;
`else
    n_eff     = n_raw;
    mask_init = req_reg_list;
`endif
    four_n  = ADDR_W'(n_eff) << 2;
    base_al = {base_addr[ADDR_W-1:2], 2'b00};

    case (bx_mode(req_in.p, req_in.u))
      IA:      start_addr = base_al;
      IB:      start_addr = base_al + WORD_BYTES;
      DA:      start_addr = base_al - four_n + WORD_BYTES;
      default: start_addr = base_al - four_n;
    endcase

    // Writeback uses the unaligned base on purpose.
    wb_calc    = req_in.u ? (base_addr + four_n) : (base_addr - four_n);
    wb_en_calc = req_in.w && !(req_in.load && req_in.reg_list[req_in.rn]);
    // LDM with R15 in the list restores CPSR instead of using the user bank.
    ub_calc    = (NUM_REGS == 16) && req_in.s &&
                 !(req_in.load && req_in.reg_list[BX_MAX_REGS-1]);
  end

  // Next-state and datapath update; flush overrides everything.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wb_d    = wb_q;
    mask_d  = mask_q;
    load_d  = load_q;
    ub_d    = ub_q;
    wb_en_d = wb_en_q;
    case (state_q)
      BX_IDLE: begin
        if (start) begin
          addr_d  = start_addr;
          wb_d    = wb_calc;
          mask_d  = mask_init;
          load_d  = req_in.load;
          ub_d    = ub_calc;
          wb_en_d = wb_en_calc;
          state_d = (mask_init == '0) ? BX_FIN : BX_XFER;
        end
      end
      BX_XFER: begin
        if (xfer_ready) begin
          addr_d = addr_q + WORD_BYTES;
          mask_d = mask_q & ~lsb_onehot;
          if (last_xfer) state_d = BX_FIN;
        end
      end
      BX_FIN:  state_d = BX_IDLE;
      default: state_d = BX_IDLE;
    endcase
    if (flush) state_d = BX_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BX_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wb_q    <= '0;
      mask_q  <= '0;
      load_q  <= 1'b0;
      ub_q    <= 1'b0;
      wb_en_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wb_q    <= wb_d;
      mask_q  <= mask_d;
      load_q  <= load_d;
      ub_q    <= ub_d;
      wb_en_q <= wb_en_d;
    end
  end

  assign in_xfer = (state_q == BX_XFER);
  assign in_fin  = (state_q == BX_FIN);

  // Outputs are gated by state so everything reads 0 outside its phase.
  assign busy           = (state_q != BX_IDLE);
  assign xfer_valid     = in_xfer;
  assign xfer_addr      = in_xfer ? addr_q : '0;
  assign xfer_reg       = in_xfer ? lsb_idx : '0;
  assign xfer_load      = in_xfer && load_q;
  assign xfer_user_bank = in_xfer && ub_q;
  assign xfer_last      = in_xfer && last_xfer;
  assign done           = in_fin && !flush;
  assign wb_valid       = in_fin && wb_en_q && !flush;
  assign wb_data        = in_fin ? wb_q : '0;

endmodule

// File: tb/tb_cpu_block_xfer_seq.sv
// Bench for cpu_block_xfer_seq: a 16-register (ARM) and an 8-register (Thumb)
// instance share request inputs; a behavioural model builds the expected
// transfer list, writeback and flags for every request.
module tb_cpu_block_xfer_seq;

  logic        clk, rst_n, flush, xfer_ready;
  logic        a_start, b_start;
  logic        req_p, req_u, req_s, req_w, req_load;
  logic [3:0]  req_rn;
  logic [15:0] req_list;
  logic [31:0] base_addr;

  logic        a_busy, a_valid, a_load, a_ub, a_last, a_wbv, a_done;
  logic [31:0] a_addr, a_wbd;
  logic [3:0]  a_reg;
  logic        b_busy, b_valid, b_load, b_ub, b_last, b_wbv, b_done;
  logic [31:0] b_addr, b_wbd;
  logic [2:0]  b_reg;

  int tests = 0;
  int fails = 0;
  bit dut_sel = 1'b0;

  logic        o_busy, o_valid, o_load, o_ub, o_last, o_wbv, o_done;
  logic [31:0] o_addr, o_wbd;
  logic [3:0]  o_reg;

  assign o_busy  = dut_sel ? b_busy  : a_busy;
  assign o_valid = dut_sel ? b_valid : a_valid;
  assign o_load  = dut_sel ? b_load  : a_load;
  assign o_ub    = dut_sel ? b_ub    : a_ub;
  assign o_last  = dut_sel ? b_last  : a_last;
  assign o_wbv   = dut_sel ? b_wbv   : a_wbv;
  assign o_done  = dut_sel ? b_done  : a_done;
  assign o_addr  = dut_sel ? b_addr  : a_addr;
  assign o_wbd   = dut_sel ? b_wbd   : a_wbd;
  assign o_reg   = dut_sel ? {1'b0, b_reg} : a_reg;

  cpu_block_xfer_seq #(.NUM_REGS(16), .ADDR_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start),
    .req_p(req_p), .req_u(req_u), .req_s(req_s), .req_w(req_w), .req_load(req_load),
    .req_rn(req_rn), .req_reg_list(req_list), .base_addr(base_addr), .flush(flush),
    .busy(a_busy), .xfer_valid(a_valid), .xfer_ready(xfer_ready), .xfer_addr(a_addr),
    .xfer_reg(a_reg), .xfer_load(a_load), .xfer_user_bank(a_ub), .xfer_last(a_last),
    .wb_valid(a_wbv), .wb_data(a_wbd), .done(a_done)
  );

  cpu_block_xfer_seq #(.NUM_REGS(8), .ADDR_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start),
    .req_p(req_p), .req_u(req_u), .req_s(req_s), .req_w(req_w), .req_load(req_load),
    .req_rn(req_rn[2:0]), .req_reg_list(req_list[7:0]), .base_addr(base_addr), .flush(flush),
    .busy(b_busy), .xfer_valid(b_valid), .xfer_ready(xfer_ready), .xfer_addr(b_addr),
    .xfer_reg(b_reg), .xfer_load(b_load), .xfer_user_bank(b_ub), .xfer_last(b_last),
    .wb_valid(b_wbv), .wb_data(b_wbd), .done(b_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One complete block transfer with model-derived expectations.
  task automatic run_seq(input bit sel, input logic p, input logic u, input logic s,
                         input logic w, input logic ld, input logic [3:0] rn_in,
                         input logic [15:0] list_in, input logic [31:0] base,
                         input int stall_at, input bit rnd_ready, input string name);
    int nregs, n, k, budget, stall_left;
    bit stalled, rdy;
    logic [3:0]  rn;
    logic [15:0] list, list_eff;
    logic [31:0] aligned, lo, exp_wb;
    bit exp_wbv, exp_ub;
    int          regs_q[$];
    logic [31:0] addrs_q[$];

    nregs = sel ? 8 : 16;
    list  = sel ? (list_in & 16'h00FF) : list_in;
    rn    = sel ? (rn_in & 4'h7) : rn_in;
    n = 0;
    for (int i = 0; i < nregs; i++) if (list[i]) n++;
    list_eff = list;
`ifdef CPU_BLOCK_XFER_EMPTY_LIST_EN
    if (n == 0) begin
      list_eff = 16'(1) << (nregs - 1);
      n = nregs;
    end
`endif
    aligned = base & 32'hFFFF_FFFC;
    if (u) lo = p ? aligned + 32'd4 : aligned;
    else   lo = p ? aligned - 32'(4 * n) : aligned - 32'(4 * n) + 32'd4;
    k = 0;
    for (int i = 0; i < nregs; i++) begin
      if (list_eff[i]) begin
        regs_q.push_back(i);
        addrs_q.push_back(lo + 32'(4 * k));
        k++;
      end
    end
    exp_wb  = u ? base + 32'(4 * n) : base - 32'(4 * n);
    exp_wbv = w && !(ld && list[rn]);
    exp_ub  = (nregs == 16) && s && !(ld && list[15]);

    dut_sel = sel;
    @(negedge clk);
    req_p = p; req_u = u; req_s = s; req_w = w; req_load = ld;
    req_rn = rn; req_list = list; base_addr = base; xfer_ready = 1'b0;
    if (sel) b_start = 1'b1; else a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0; b_start = 1'b0;

    k = 0; budget = 0; stalled = 0; stall_left = 0;
    while (k < regs_q.size()) begin
      tests++;
      if ({o_reg, o_addr, o_last} !== {4'(regs_q[k]), addrs_q[k], (k == regs_q.size() - 1)}) begin
        fails++;
        $display("FAIL %s xfer%0d got reg=%0d addr=%h last=%b expected reg=%0d addr=%h last=%b",
                 name, k, o_reg, o_addr, o_last, regs_q[k], addrs_q[k], (k == regs_q.size() - 1));
      end
      tests++;
      if ({o_valid, o_load, o_ub, o_busy, o_done} !== {1'b1, ld, exp_ub, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL %s flags%0d got valid/load/ub/busy/done=%b expected %b",
                 name, k, {o_valid, o_load, o_ub, o_busy, o_done}, {1'b1, ld, exp_ub, 1'b1, 1'b0});
      end
      if (k == stall_at && !stalled) begin
        stalled = 1; stall_left = 3;
      end
      if (stall_left > 0) begin
        rdy = 1'b0; stall_left--;
      end else begin
        rdy = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      xfer_ready = rdy;
      @(negedge clk);
      if (rdy) k++;
      budget++;
      if (budget > 400) begin
        tests++; fails++;
        $display("FAIL %s timeout got %0d transfers expected %0d", name, k, regs_q.size());
        break;
      end
    end
    xfer_ready = 1'b0;

    tests++;
    if ({o_done, o_valid, o_busy, o_wbv} !== {1'b1, 1'b0, 1'b1, exp_wbv}) begin
      fails++;
      $display("FAIL %s fin got done/valid/busy/wbv=%b expected %b",
               name, {o_done, o_valid, o_busy, o_wbv}, {1'b1, 1'b0, 1'b1, exp_wbv});
    end
    tests++;
    if (o_wbd !== exp_wb) begin
      fails++;
      $display("FAIL %s wb_data got %h expected %h", name, o_wbd, exp_wb);
    end
    @(negedge clk);
    tests++;
    if ({o_done, o_busy, o_wbv} !== 3'b000) begin
      fails++;
      $display("FAIL %s post got done/busy/wbv=%b expected 000", name, {o_done, o_busy, o_wbv});
    end
  endtask

  task automatic test_reset();
    tests++;
    if ({a_busy, a_valid, a_load, a_ub, a_last, a_wbv, a_done, a_reg, a_addr, a_wbd} !== '0) begin
      fails++;
      $display("FAIL reset16 got nonzero outputs addr=%h wb=%h busy=%b", a_addr, a_wbd, a_busy);
    end
    tests++;
    if ({b_busy, b_valid, b_load, b_ub, b_last, b_wbv, b_done, b_reg, b_addr, b_wbd} !== '0) begin
      fails++;
      $display("FAIL reset8 got nonzero outputs addr=%h wb=%h busy=%b", b_addr, b_wbd, b_busy);
    end
  endtask

  task automatic test_directed();
    run_seq(0, 0, 1, 0, 1, 0, 4'd13, 16'h000B, 32'h0300_0000, -1, 0, "stmia");
    run_seq(0, 1, 0, 0, 1, 1, 4'd0,  16'h8010, 32'h0300_0100, -1, 0, "ldmdb");
    run_seq(0, 0, 1, 0, 1, 1, 4'd2,  16'h0006, 32'h0000_2000, -1, 0, "ldm_base_in_list");
    run_seq(0, 1, 1, 1, 0, 0, 4'd1,  16'h0301, 32'h0000_1003, -1, 0, "stmib_user");
    run_seq(0, 0, 0, 1, 1, 1, 4'd0,  16'h8006, 32'h0000_4000, -1, 0, "ldmda_r15_s");
    run_seq(0, 0, 1, 0, 1, 0, 4'd0,  16'h0070, 32'hFFFF_FFF8, -1, 0, "wrap");
  endtask

  task automatic test_stall();
    run_seq(0, 0, 1, 0, 1, 1, 4'd9, 16'h00F0, 32'h0000_8000, 1, 0, "stall");
  endtask

  task automatic test_empty_list();
    run_seq(0, 1, 0, 0, 1, 0, 4'd13, 16'h0000, 32'h0000_0100, -1, 0, "empty16");
    run_seq(1, 0, 1, 0, 1, 1, 4'd5,  16'h0000, 32'h0000_0200, -1, 0, "empty8");
  endtask

  task automatic test_thumb_push();
    run_seq(1, 1, 0, 1, 1, 0, 4'd7, 16'h00FF, 32'h0300_7F00, -1, 0, "push8");
  endtask

  task automatic test_flush();
    dut_sel = 0;
    @(negedge clk);
    req_p = 0; req_u = 1; req_s = 0; req_w = 1; req_load = 0;
    req_rn = 4'd0; req_list = 16'h00F0; base_addr = 32'h0000_2000;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0; xfer_ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({o_valid, o_reg, o_addr} !== {1'b1, 4'd5, 32'h0000_2004}) begin
      fails++;
      $display("FAIL flush_pre got valid=%b reg=%0d addr=%h expected 1 5 00002004", o_valid, o_reg, o_addr);
    end
    flush = 1'b1; xfer_ready = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    tests++;
    if ({o_busy, o_valid, o_done, o_wbv} !== 4'b0000) begin
      fails++;
      $display("FAIL flush_idle got busy/valid/done/wbv=%b expected 0000", {o_busy, o_valid, o_done, o_wbv});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if ({o_busy, o_done, o_wbv} !== 3'b000) begin
        fails++;
        $display("FAIL flush_quiet%0d got busy/done/wbv=%b expected 000", i, {o_busy, o_done, o_wbv});
      end
    end
    a_start = 1'b1; flush = 1'b1;
    @(negedge clk);
    a_start = 1'b0; flush = 1'b0;
    tests++;
    if ({o_busy, o_valid} !== 2'b00) begin
      fails++;
      $display("FAIL flush_beats_start got busy/valid=%b expected 00", {o_busy, o_valid});
    end
  endtask

  task automatic test_random();
    logic [15:0] l;
    for (int i = 0; i < 40; i++) begin
      l = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      run_seq(i >= 30, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              4'($urandom), l, $urandom, -1, 1, "random");
    end
  endtask

  task automatic test_mid_reset();
    dut_sel = 0;
    @(negedge clk);
    req_p = 0; req_u = 1; req_s = 1; req_w = 1; req_load = 1;
    req_rn = 4'd0; req_list = 16'h0F0F; base_addr = 32'h0000_4000;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0; xfer_ready = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({a_busy, a_valid, a_load, a_ub, a_last, a_wbv, a_done, a_reg, a_addr, a_wbd} !== '0) begin
      fails++;
      $display("FAIL mid_reset got busy=%b valid=%b addr=%h reg=%0d expected all 0", a_busy, a_valid, a_addr, a_reg);
    end
    xfer_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({a_busy, a_valid} !== 2'b00) begin
      fails++;
      $display("FAIL post_reset got busy/valid=%b expected 00", {a_busy, a_valid});
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; xfer_ready = 1'b0; a_start = 1'b0; b_start = 1'b0;
    req_p = 0; req_u = 0; req_s = 0; req_w = 0; req_load = 0;
    req_rn = '0; req_list = '0; base_addr = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_directed();
    test_stall();
    test_flush();
    test_empty_list();
    test_thumb_push();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
